// File: rtl/bank_register_mp.sv
// Multi-read-port register file with per-port write bypass, optional hardwired
// zero register, and a valid/ready dump sequencer that streams every register.
module bank_register_mp #(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32,
  parameter int N_READ     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       we_i,
  input  logic [NB_REG-1:0]          addr_w_i,
  input  logic [NB_DATA-1:0]         data_w_i,
  input  logic [N_READ*NB_REG-1:0]   addr_r_i,
  output logic [N_READ*NB_DATA-1:0]  data_r_o,
  input  logic                       dump_start_i,
  input  logic                       dump_ready_i,
  output logic                       dump_valid_o,
  output logic [NB_REG-1:0]          dump_addr_o,
  output logic [NB_DATA-1:0]         dump_data_o,
  output logic                       dump_busy_o,
  output logic                       dump_done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGISTER - 1);

  logic [NB_DATA-1:0] regs [N_REGISTER];
  logic [1:0]         state;
  logic [NB_REG-1:0]  next_idx;
  logic               wr_en;

  // Value any read port would register for addr this cycle: zero register
  // first, then range check, then same-cycle write bypass, then storage.
  function automatic logic [NB_DATA-1:0] read_value(input logic [NB_REG-1:0] addr);
    logic [NB_DATA-1:0] val;
    val = '0;
    if (ZERO_REG != 0 && addr == '0)
      val = '0;
    else if (int'(addr) >= N_REGISTER)
      val = '0;
    else if (we_i && addr_w_i == addr)
      val = data_w_i;
    else
      val = regs[addr];
    return val;
  endfunction

  assign wr_en    = we_i && (int'(addr_w_i) < N_REGISTER) &&
                    !(ZERO_REG != 0 && addr_w_i == '0);
  assign next_idx = dump_addr_o + NB_REG'(1);

  // NOTE: the storage array is reset because reset must clear the architectural
  // state; this rules out RAM-macro inference, which is acceptable at this size.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < N_REGISTER; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[addr_w_i] <= data_w_i;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every reader in the
  // same edge sees the pre-edge value, which is what makes the bypass work.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      data_r_o <= '0;
    end else begin
      for (int k = 0; k < N_READ; k++)
        data_r_o[k*NB_DATA +: NB_DATA] <= read_value(addr_r_i[k*NB_REG +: NB_REG]);
    end
  end

  // dump_addr_o doubles as the dump index; it never wraps inside a dump.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= ST_IDLE;
      dump_valid_o <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
      dump_busy_o  <= 1'b0;
      dump_done_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dump_done_o <= 1'b0;
          if (dump_start_i) begin
            state        <= ST_SEND;
            dump_valid_o <= 1'b1;
            dump_busy_o  <= 1'b1;
            dump_addr_o  <= '0;
            dump_data_o  <= read_value('0);
          end
        end
        ST_SEND: begin
          if (dump_ready_i) begin
            if (dump_addr_o == LAST_IDX) begin
              state        <= ST_DONE;
              dump_valid_o <= 1'b0;
              dump_done_o  <= 1'b1;
            end else begin
              dump_addr_o <= next_idx;
              dump_data_o <= read_value(next_idx);
            end
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          dump_done_o <= 1'b0;
          dump_busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_register_mp.sv
// Bench for bank_register_mp: two instances (zero register on/off) share the
// stimulus and are checked every cycle against a behavioural model.
module tb_bank_register_mp;

  localparam int NB_REG  = 5;
  localparam int NB_DATA = 32;
  localparam int NREG    = 32;
  localparam int NRD     = 2;

  logic                    clock_i = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    we_i = 1'b0;
  logic [NB_REG-1:0]       addr_w_i = '0;
  logic [NB_DATA-1:0]      data_w_i = '0;
  logic [NRD*NB_REG-1:0]   addr_r_i = '0;
  logic                    dump_start_i = 1'b0;
  logic                    dump_ready_i = 1'b1;

  logic [NRD*NB_DATA-1:0]  rd1, rd0;
  logic                    valid1, valid0, busy1, busy0, done1, done0;
  logic [NB_REG-1:0]       daddr1, daddr0;
  logic [NB_DATA-1:0]      ddata1, ddata0;

  int compared   = 0;
  int mismatched = 0;
  bit cmp_en     = 1'b0;

  always #5 clock_i = ~clock_i;

  bank_register_mp #(.NB_REG(NB_REG), .NB_DATA(NB_DATA), .N_REGISTER(NREG),
                     .N_READ(NRD), .ZERO_REG(1)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .we_i(we_i), .addr_w_i(addr_w_i),
    .data_w_i(data_w_i), .addr_r_i(addr_r_i), .data_r_o(rd1),
    .dump_start_i(dump_start_i), .dump_ready_i(dump_ready_i),
    .dump_valid_o(valid1), .dump_addr_o(daddr1), .dump_data_o(ddata1),
    .dump_busy_o(busy1), .dump_done_o(done1));

  bank_register_mp #(.NB_REG(NB_REG), .NB_DATA(NB_DATA), .N_REGISTER(NREG),
                     .N_READ(NRD), .ZERO_REG(0)) dut_z0 (
    .clock_i(clock_i), .reset_i(reset_i), .we_i(we_i), .addr_w_i(addr_w_i),
    .data_w_i(data_w_i), .addr_r_i(addr_r_i), .data_r_o(rd0),
    .dump_start_i(dump_start_i), .dump_ready_i(dump_ready_i),
    .dump_valid_o(valid0), .dump_addr_o(daddr0), .dump_data_o(ddata0),
    .dump_busy_o(busy0), .dump_done_o(done0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register contents follow every in-range write; the zero-register instance
  // differs only in that address 0 always reads 0.
  logic [31:0] m_regs [NREG];
  logic [31:0] exp_rd1 [NRD];
  logic [31:0] exp_rd0 [NRD];
  int          phase = -1;  // -1 idle, 0..NREG-1 presenting word, NREG done cycle
  logic [31:0] w1, w0;

  function automatic logic [31:0] m_read(input int a, input bit zr);
    if (zr && a == 0) return 32'h0;
    if (a >= NREG) return 32'h0;
    if (we_i && int'(addr_w_i) == a) return data_w_i;
    return m_regs[a];
  endfunction

  always @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
      for (int k = 0; k < NRD; k++) begin
        exp_rd1[k] = 32'h0;
        exp_rd0[k] = 32'h0;
      end
      phase = -1;
      w1 = 32'h0;
      w0 = 32'h0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        exp_rd1[k] = m_read(int'(addr_r_i[k*NB_REG +: NB_REG]), 1'b1);
        exp_rd0[k] = m_read(int'(addr_r_i[k*NB_REG +: NB_REG]), 1'b0);
      end
      if (phase < 0) begin
        if (dump_start_i) begin
          phase = 0;
          w1 = m_read(0, 1'b1);
          w0 = m_read(0, 1'b0);
        end
      end else if (phase < NREG) begin
        if (dump_ready_i) begin
          phase++;
          if (phase < NREG) begin
            w1 = m_read(phase, 1'b1);
            w0 = m_read(phase, 1'b0);
          end
        end
      end else begin
        phase = -1;
      end
      if (we_i && int'(addr_w_i) < NREG) m_regs[addr_w_i] = data_w_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock_i) begin
    if (cmp_en) begin
      bit ev;
      ev = (phase >= 0 && phase < NREG);
      check("rd_z1_p0", rd1[31:0],  exp_rd1[0]);
      check("rd_z1_p1", rd1[63:32], exp_rd1[1]);
      check("rd_z0_p0", rd0[31:0],  exp_rd0[0]);
      check("rd_z0_p1", rd0[63:32], exp_rd0[1]);
      check("valid_z1", 32'(valid1), 32'(ev));
      check("valid_z0", 32'(valid0), 32'(ev));
      check("busy_z1",  32'(busy1),  32'(phase >= 0));
      check("busy_z0",  32'(busy0),  32'(phase >= 0));
      check("done_z1",  32'(done1),  32'(phase == NREG));
      check("done_z0",  32'(done0),  32'(phase == NREG));
      if (ev) begin
        check("daddr_z1", 32'(daddr1), 32'(phase));
        check("daddr_z0", 32'(daddr0), 32'(phase));
        check("ddata_z1", ddata1, w1);
        check("ddata_z0", ddata0, w0);
      end
    end
  end

  // Accepted-word log and done-pulse counter, read by the directed sequence.
  logic [31:0] got_data [NREG];
  int          acc_cnt  = 0;
  int          done_cnt = 0;

  always @(negedge clock_i) begin
    if (valid1 && dump_ready_i) begin
      got_data[daddr1] = ddata1;
      acc_cnt++;
    end
    if (done1) done_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    addr_r_i = {NB_REG'(a1), NB_REG'(a0)};
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we_i = 1'b1;
    addr_w_i = NB_REG'(a);
    data_w_i = d;
    cyc();
    we_i = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < NREG; i++) wr(i, 32'(i) * 32'h11);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc();
      if (done1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int a0, d0;

    #2 reset_i = 1'b0;
    cmp_en = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b1;
    check("reset_rd",    rd1[31:0], 32'h0);
    check("reset_valid", 32'(valid1), 32'h0);
    check("reset_busy",  32'(busy1),  32'h0);

    // Reset asserted asynchronously in the middle of write traffic.
    preload();
    we_i = 1'b1; addr_w_i = 5'd9; data_w_i = 32'hCAFE_F00D;
    set_rd(5, 6);
    #2 reset_i = 1'b0;
    #1;
    check("async_rst_rd0", rd1[31:0],  32'h0);
    check("async_rst_rd1", rd1[63:32], 32'h0);
    check("async_rst_valid", 32'(valid1), 32'h0);
    cyc();
    reset_i = 1'b1;
    we_i = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      set_rd(i, NREG - 1 - i);
      cyc();
      check("post_rst_read", rd0[31:0] | rd0[63:32], 32'h0);
    end

    // Bypass on both ports, then one port bypassing and one reading storage.
    preload();
    we_i = 1'b1; addr_w_i = 5'd7; data_w_i = 32'hDEAD_BEEF;
    set_rd(7, 7);
    cyc();
    check("bypass_p0", rd1[31:0],  32'hDEAD_BEEF);
    check("bypass_p1", rd1[63:32], 32'hDEAD_BEEF);
    data_w_i = 32'h77;
    set_rd(7, 8);
    cyc();
    we_i = 1'b0;
    check("bypass_p0_new", rd1[31:0],  32'h77);
    check("nobypass_p1",   rd1[63:32], 32'h88);

    // Zero register on vs off.
    wr(0, 32'h1234_5678);
    set_rd(0, 0);
    cyc();
    check("zero_reg_z1_p0", rd1[31:0],  32'h0);
    check("zero_reg_z1_p1", rd1[63:32], 32'h0);
    check("zero_reg_z0_p0", rd0[31:0],  32'h1234_5678);
    check("zero_reg_z0_p1", rd0[63:32], 32'h1234_5678);
    wr(0, 32'h0);

    // Full dump with ready held high.
    dump_ready_i = 1'b1;
    a0 = acc_cnt; d0 = done_cnt;
    dump_start_i = 1'b1;
    cyc();
    dump_start_i = 1'b0;
    check("dump_first_addr",  32'(daddr1), 32'h0);
    check("dump_first_valid", 32'(valid1), 32'h1);
    wait_done("full_dump_done");
    cyc();
    check("full_dump_words", 32'(acc_cnt - a0), 32'd32);
    check("full_dump_pulses", 32'(done_cnt - d0), 32'd1);
    check("full_dump_busy_low", 32'(busy1), 32'h0);
    for (int i = 0; i < NREG; i++)
      check("full_dump_data", got_data[i], 32'(i) * 32'h11);

    // Backpressure on word 3 with concurrent writes.
    dump_ready_i = 1'b0;
    dump_start_i = 1'b1;
    cyc();
    dump_start_i = 1'b0;
    dump_ready_i = 1'b1;
    repeat (3) cyc();
    dump_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      we_i = (s == 1);
      addr_w_i = 5'd3;
      data_w_i = 32'hAAAA;
      cyc();
      check("stall_addr", 32'(daddr1), 32'd3);
      check("stall_data", ddata1, 32'h33);
    end
    dump_ready_i = 1'b1;
    we_i = 1'b1; addr_w_i = 5'd4; data_w_i = 32'hBBBB;
    cyc();
    we_i = 1'b0;
    check("word4_addr", 32'(daddr1), 32'd4);
    check("word4_bypass", ddata1, 32'hBBBB);
    wait_done("stall_dump_done");
    cyc();

    // Reset in the middle of a dump aborts it without a done pulse.
    d0 = done_cnt;
    dump_start_i = 1'b1;
    cyc();
    dump_start_i = 1'b0;
    repeat (10) cyc();
    check("pre_abort_addr", 32'(daddr1), 32'd10);
    #2 reset_i = 1'b0;
    #1;
    check("abort_valid", 32'(valid1), 32'h0);
    check("abort_busy",  32'(busy1),  32'h0);
    cyc();
    reset_i = 1'b1;
    repeat (3) cyc();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    dump_start_i = 1'b1;
    cyc();
    dump_start_i = 1'b0;
    check("restart_addr",  32'(daddr1), 32'h0);
    check("restart_valid", 32'(valid1), 32'h1);
    wait_done("restart_dump_done");
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
